serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
Bit-serial WIDTH-bit adder built around the team's one-bit FullAdder cell. It latches two parallel operands and a carry-in on a start request, then feeds the FullAdder one bit pair per clock, LSB first, through operand shift registers and a carry flip-flop. It reassembles the sum in a result shift register and presents a parallel sum/carry-out with a done pulse. It sits directly upstream of the FullAdder cell, as its sequencing and operand-feeding stage.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 1..32.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request a new addition; sampled on rising clk
a  input  WIDTH  operand A; captured only when start is accepted
b  input  WIDTH  operand B; captured only when start is accepted
cIn  input  1  carry-in; captured only when start is accepted
busy  output  1  high while an addition is in progress (state RUN)
done  output  1  one-cycle pulse when sum/cOut become valid
sum  output  WIDTH  result of last completed addition
cOut  output  1  carry-out of last completed addition

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low. While rst_n=0 the state is IDLE, busy=0, done=0, sum=0, cOut=0, and the internal shift registers, bit counter and carry flop are 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at an edge -> load opA<=a, opB<=b, carry<=cIn, cnt<=0; go to RUN.
  - RUN: each edge, FullAdder inputs are opA[0], opB[0], carry. Its sum bit shifts into the MSB of the result register (shift right). carry<=FullAdder cOut. opA and opB shift right by 1. cnt increments. When cnt reaches WIDTH-1 on this edge: transfer the completed result to sum, the new carry to cOut, and go to DONE.
  - DONE: done=1 for exactly this one cycle. start=1 here is accepted exactly as in IDLE and goes to RUN. Otherwise go to IDLE.
- Latency: start accepted at edge k -> RUN occupies edges k+1..k+WIDTH -> done=1 and sum/cOut valid in the cycle after edge k+WIDTH. That gives WIDTH cycles of busy and a throughput of one addition per WIDTH+1 cycles.
- busy=1 only in RUN. done=1 only in DONE. Both are registered state decodes with no combinational path from start.
- start while in RUN is ignored: no restart, and operands are not re-captured.
- a, b and cIn may change freely after the accepting edge without affecting the operation in flight.
- sum and cOut hold the last completed result through IDLE and any subsequent RUN. They change only at the completing edge and at reset.
- Arithmetic: {cOut,sum} = a + b + cIn, modulo 2^(WIDTH+1). This is unsigned; signed overflow is not flagged.
- Counter width: $clog2(WIDTH) bits, minimum 1. For WIDTH=1, RUN lasts exactly one cycle.
- Reset asserted mid-RUN: the operation is aborted immediately. Outputs clear to 0, and no done pulse is produced for the aborted operation.

Decomposition:
- Shared package serial_adder_pkg:
  - enum type adder_state_t {IDLE, RUN, DONE}
  - constant DEFAULT_WIDTH = 8
- Sub-module: instantiate the existing FullAdder cell once for the per-bit datapath. The carry flop, shift registers, counter and FSM live in serial_adder.

Test Plan:
- WIDTH=8, reset then a=0x5A, b=0x3C, cIn=0, start for 1 cycle -> busy high 8 cycles; then done=1 for 1 cycle with sum=0x96, cOut=0.
- a=0xFF, b=0x01, cIn=0 -> sum=0x00, cOut=1. Then a=0xFF, b=0xFF, cIn=1 -> sum=0xFF, cOut=1.
- Start 0x12+0x34; hold start high and drive a=0xAA, b=0x55 throughout RUN -> done after 8 busy cycles with sum=0x46, cOut=0. The second request is accepted in DONE and yields sum=0xFF, cOut=0 after 8 further busy cycles.
- Start 0x80+0x80, assert rst_n=0 at busy cycle 4 -> busy, done, sum and cOut all 0 immediately with no done pulse. After release, 0x01+0x01 -> sum=0x02.
- WIDTH=1 instance: a=1, b=1, cIn=1 -> busy for 1 cycle, then sum=1, cOut=1. Also sweep all 8 input combinations against the FullAdder truth table.
- Random regression (WIDTH=8 and 13, 1000 ops with random gaps and random start glitches during RUN) -> every done matches the reference model a+b+cIn, and sum/cOut are stable between done pulses.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } adder_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit full adder cell used as the per-bit datapath of the serial adder.
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic cIn,
  output logic sum,
  output logic cOut
);

  assign sum  = a ^ b ^ cIn;
  assign cOut = (a & b) | (cIn & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: latches operands on start, adds one bit pair per
// clock LSB first through a FullAdder, then presents sum/cOut with a done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cOut
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  adder_state_t     state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] res_shift;

  FullAdder u_fa (
    .a    (op_a_q[0]),
    .b    (op_b_q[0]),
    .cIn  (carry_q),
    .sum  (fa_sum),
    .cOut (fa_cout)
  );

  // New sum bit enters at the MSB so the LSB computed first ends up at bit 0.
  assign res_shift = (res_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          op_a_d  = a;
          op_b_d  = b;
          carry_d = cIn;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        op_a_d  = op_a_q >> 1;
        op_b_d  = op_b_q >> 1;
        res_d   = res_shift;
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          sum_d   = res_shift;
          cout_d  = fa_cout;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cOut = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH 8, 13 and 1 against an
// arithmetic reference model {cOut,sum} = a + b + cIn.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [12:0] a_in, b_in;
  logic        cin;
  int          sel;

  logic        st8, st13, st1;
  logic        busy8, done8, cout8;
  logic        busy13, done13, cout13;
  logic        busy1, done1, cout1;
  logic [7:0]  sum8;
  logic [12:0] sum13;
  logic        sum1;

  logic        obs_busy, obs_done, obs_cout;
  logic [12:0] obs_sum;

  int          checks = 0;
  int          errors = 0;
  logic [12:0] last_sum [3];
  logic        last_cout [3];

  always #5 clk = ~clk;

  assign st8  = start && (sel == 0);
  assign st13 = start && (sel == 1);
  assign st1  = start && (sel == 2);

  serial_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .a(a_in[7:0]), .b(b_in[7:0]), .cIn(cin),
    .busy(busy8), .done(done8), .sum(sum8), .cOut(cout8)
  );

  serial_adder #(.WIDTH(13)) u_w13 (
    .clk(clk), .rst_n(rst_n), .start(st13), .a(a_in), .b(b_in), .cIn(cin),
    .busy(busy13), .done(done13), .sum(sum13), .cOut(cout13)
  );

  serial_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .a(a_in[0]), .b(b_in[0]), .cIn(cin),
    .busy(busy1), .done(done1), .sum(sum1), .cOut(cout1)
  );

  always_comb begin
    obs_busy = busy8;
    obs_done = done8;
    obs_sum  = {5'd0, sum8};
    obs_cout = cout8;
    if (sel == 1) begin
      obs_busy = busy13;
      obs_done = done13;
      obs_sum  = sum13;
      obs_cout = cout13;
    end else if (sel == 2) begin
      obs_busy = busy1;
      obs_done = done1;
      obs_sum  = {12'd0, sum1};
      obs_cout = cout1;
    end
  end

  function automatic int width_of(int s);
    return (s == 0) ? 8 : ((s == 1) ? 13 : 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s w=%0d observed=%0h expected=%0h", tag, width_of(sel), obs, exp);
    end
  endtask

  task automatic chk_hold();
    chk("sum_hold", 32'(obs_sum), 32'(last_sum[sel]));
    chk("cout_hold", 32'(obs_cout), 32'(last_cout[sel]));
  endtask

  // Called in the first RUN cycle; walks through RUN and checks the DONE cycle.
  task automatic wait_run(int w, logic [12:0] es, logic ec, bit glitch);
    for (int i = 0; i < w; i++) begin
      chk("busy_run", 32'(obs_busy), 32'd1);
      chk("done_run", 32'(obs_done), 32'd0);
      chk_hold();
      if (glitch) begin
        start = 1'($urandom_range(0, 1));
        a_in  = 13'($urandom);
        b_in  = 13'($urandom);
        cin   = 1'($urandom_range(0, 1));
      end
      step();
    end
    if (glitch) start = 1'b0;
    chk("done_pulse", 32'(obs_done), 32'd1);
    chk("busy_done", 32'(obs_busy), 32'd0);
    chk("sum_result", 32'(obs_sum), 32'(es));
    chk("cout_result", 32'(obs_cout), 32'(ec));
    last_sum[sel]  = es;
    last_cout[sel] = ec;
  endtask

  task automatic model(int w, logic [12:0] a, logic [12:0] b, logic c,
                       output logic [12:0] es, output logic ec);
    logic [31:0] mask;
    logic [31:0] tot;
    mask = (32'd1 << w) - 32'd1;
    tot  = (32'(a) & mask) + (32'(b) & mask) + 32'(c);
    es   = 13'(tot & mask);
    ec   = tot[w];
  endtask

  task automatic run_op(int s, logic [12:0] a, logic [12:0] b, logic c, bit glitch);
    int          w;
    logic [12:0] es;
    logic        ec;
    sel = s;
    w   = width_of(s);
    model(w, a, b, c, es, ec);
    a_in  = a;
    b_in  = b;
    cin   = c;
    start = 1'b1;
    step();
    start = 1'b0;
    if (glitch) begin
      a_in = 13'($urandom);
      b_in = 13'($urandom);
      cin  = 1'($urandom_range(0, 1));
    end
    wait_run(w, es, ec, glitch);
    step();
    chk("done_one_cycle", 32'(obs_done), 32'd0);
    chk("busy_idle", 32'(obs_busy), 32'd0);
    chk_hold();
  endtask

  initial begin
    logic [12:0] ra, rb;
    logic        rc;
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = 13'h1FFF;
    b_in  = 13'h1FFF;
    cin   = 1'b1;
    sel   = 0;
    for (int s = 0; s < 3; s++) begin
      last_sum[s]  = '0;
      last_cout[s] = 1'b0;
    end
    step();
    step();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst_busy", 32'(obs_busy), 32'd0);
      chk("rst_done", 32'(obs_done), 32'd0);
      chk("rst_sum", 32'(obs_sum), 32'd0);
      chk("rst_cout", 32'(obs_cout), 32'd0);
    end
    rst_n = 1'b1;
    sel   = 0;
    step();

    // Directed WIDTH=8 operations
    run_op(0, 13'h5A, 13'h3C, 1'b0, 1'b0);
    run_op(0, 13'hFF, 13'h01, 1'b0, 1'b0);
    run_op(0, 13'hFF, 13'hFF, 1'b1, 1'b0);

    // Start held high: ignored during RUN, accepted again in DONE
    sel   = 0;
    a_in  = 13'h12;
    b_in  = 13'h34;
    cin   = 1'b0;
    start = 1'b1;
    step();
    a_in = 13'hAA;
    b_in = 13'h55;
    wait_run(8, 13'h46, 1'b0, 1'b0);
    step();
    start = 1'b0;
    wait_run(8, 13'hFF, 1'b0, 1'b0);
    step();
    chk("b2b_idle_done", 32'(obs_done), 32'd0);

    // Reset in the 4th busy cycle aborts the operation
    sel   = 0;
    a_in  = 13'h80;
    b_in  = 13'h80;
    cin   = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("abort_busy", 32'(obs_busy), 32'd1);
      step();
    end
    rst_n = 1'b0;
    #1;
    chk("abort_busy0", 32'(obs_busy), 32'd0);
    chk("abort_done0", 32'(obs_done), 32'd0);
    chk("abort_sum0", 32'(obs_sum), 32'd0);
    chk("abort_cout0", 32'(obs_cout), 32'd0);
    step();
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      last_sum[s]  = '0;
      last_cout[s] = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      chk("abort_no_done", 32'(obs_done), 32'd0);
      chk("abort_no_busy", 32'(obs_busy), 32'd0);
      step();
    end
    run_op(0, 13'h01, 13'h01, 1'b0, 1'b0);

    // WIDTH=1 instance: full truth-table sweep
    run_op(2, 13'd1, 13'd1, 1'b1, 1'b0);
    for (int v = 0; v < 8; v++) begin
      logic [2:0] vb;
      vb = 3'(v);
      run_op(2, {12'd0, vb[2]}, {12'd0, vb[1]}, vb[0], 1'b0);
    end

    // Random regression on WIDTH 8 and 13 with gaps and start glitches
    for (int n = 0; n < 1000; n++) begin
      int s;
      s  = int'($urandom_range(0, 1));
      ra = 13'($urandom);
      rb = 13'($urandom);
      rc = 1'($urandom_range(0, 1));
      run_op(s, ra, rb, rc, 1'b1);
      repeat ($urandom_range(0, 3)) begin
        step();
        chk("gap_done", 32'(obs_done), 32'd0);
        chk_hold();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
